cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Arbitrates execution-unit results onto the common data bus (CDB) that writes the physical register file and wakes up dependents. Each execution unit hands its result over a valid/ready handshake into a private one-entry holding slot. Each cycle the block grants up to CDB_WIDTH held results in rotating (round-robin) priority and drives them onto registered CDB lanes. It sits between the execution units and the PRF write side, the reservation stations and the ROB.

## Interface
- NUM_REQ, 4, number of requesting execution units; must be ≥ 1.
- CDB_WIDTH, params package value (2), number of broadcast lanes.
- PRF_IDX_HIBIT, params package value, physical register index MSB.
- ROB_IDX_HIBIT, params package value, ROB index MSB.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush; drops all held and outgoing results.
- req_valid[NUM_REQ]  in  1  requester i presents a result.
- req_ready[NUM_REQ]  out  1  slot i can accept this cycle.
- req_prd_s[NUM_REQ]  in  PRF_IDX_HIBIT+1  destination physical register.
- req_prd_v[NUM_REQ]  in  32  result value.
- req_rob_idx[NUM_REQ]  in  ROB_IDX_HIBIT+1  ROB entry to mark done.
- cdb_bc[CDB_WIDTH]  out  1  lane k carries a valid broadcast.
- cdb_prd_s[CDB_WIDTH]  out  PRF_IDX_HIBIT+1  broadcast destination.
- cdb_prd_v[CDB_WIDTH]  out  32  broadcast value.
- cdb_rob_idx[CDB_WIDTH]  out  ROB_IDX_HIBIT+1  broadcast ROB index.

## Operation
- Per requester, one slot holds {valid, prd_s, prd_v, rob_idx}.
- Slot load: req_valid[i] && req_ready[i] at the edge.
- req_ready[i] = !flush && (!slot_valid[i] || grant[i]).
  - It does not depend on req_valid, so there is no combinational loop.
  - A granted slot accepts a new result in the same cycle: one result per cycle per requester.
- Grant: scan slot indices rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - The first CDB_WIDTH valid slots are granted.
  - The n-th granted slot in scan order maps to lane n.
  - Lanes beyond the grant count are idle.
- Lane outputs are registered.
  - Granted lanes: cdb_bc=1 plus slot contents at the next edge.
  - Idle lanes: cdb_bc=0 and all data fields 0.
- rr_ptr ← (index of last granted slot + 1) mod NUM_REQ; unchanged if no grant. Width $clog2(NUM_REQ), minimum 1 bit.
- prd_s = 0 is broadcast normally, so the ROB sees completion; PRF reads of p0 return 0 regardless.
- flush, which has priority over grant/accept, at the edge:
  - all slot_valid ← 0;
  - all cdb_bc and lane data ← 0;
  - rr_ptr is held.
  - Requests offered during the flush cycle are not accepted.
- NUM_REQ < CDB_WIDTH: lanes ≥ NUM_REQ are permanently idle.

## Timing
- Reset, applied immediately on assertion and independent of clk:
  - slot_valid=0 and rr_ptr=0;
  - cdb_bc=0 and all cdb data=0;
  - req_ready=1 (for flush=0).
- Minimum latency:
  - request accepted in cycle t, slot valid in t+1;
  - if granted in t+1, cdb_bc high in t+2 for exactly one cycle per result.
- Throughput: CDB_WIDTH broadcasts/cycle in total; at most 1 per requester per cycle.
- Starvation bound: a held slot is granted within ceil(NUM_REQ/CDB_WIDTH) cycles.
- Reset mid-stream drops all held and in-flight results; nothing is broadcast after reset deasserts until new requests are accepted.

## Structure
- Params package:
  - CDB_WIDTH, PRF/ROB index widths;
  - typedef cdb_entry_t {prd_s, prd_v, rob_idx}, shared by the slot, lane and PRF/RS consumers.
- Sub-module cdb_rr_picker (combinational):
  - inputs: valid vector, rr_ptr;
  - outputs: per-lane one-hot select, lane-valid vector, next rr_ptr.
- The top module holds the slots, lane registers and rr_ptr.

## Test plan
- Single result: req0 presents prd=5, v=0xDEADBEEF, rob=3 in cycle 0 → cycle 2 shows cdb_bc[0]=1 with those values, cdb_bc[1]=0; cycle 3 shows all cdb_bc=0.
- Burst, NUM_REQ=4, CDB_WIDTH=2, rr_ptr=0, all four valid in cycle 0 → lanes carry slots {0,1} in cycle 2 and {2,3} in cycle 3; rr_ptr goes 0→2→0.
- Fairness: req0–2 valid every cycle, 2 lanes → successive grant sets {0,1}, {2,0}, {1,2}, repeating; no requester is skipped twice in a row.
- Streaming: req1 valid every cycle with rob=0,1,2,… → req_ready[1] stays 1 and one broadcast per cycle arrives in order.
- Flush with all slots full and lanes busy → next cycle all cdb_bc=0 and all req_ready=1; no stale result ever appears on the CDB.
- Async rst pulsed between edges mid-burst → cdb_bc drops to 0 before the next edge and rr_ptr=0; the first post-reset request is broadcast 2 cycles after acceptance.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and widths used by the arbiter, its interface and the bus consumers.
package cdb_arbiter_pkg;

    localparam int unsigned CDB_WIDTH     = 2;
    localparam int unsigned PRF_IDX_HIBIT = 6;
    localparam int unsigned ROB_IDX_HIBIT = 5;

    typedef logic [PRF_IDX_HIBIT:0] prf_idx_t;
    typedef logic [ROB_IDX_HIBIT:0] rob_idx_t;

    // One completed result as held in a slot and as carried on a CDB lane.
    typedef struct packed {
        prf_idx_t    prd_s;
        logic [31:0] prd_v;
        rob_idx_t    rob_idx;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit request side and CDB broadcast side of the arbiter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    prf_idx_t [NUM_REQ-1:0]     req_prd_s;
    logic [NUM_REQ-1:0][31:0]   req_prd_v;
    rob_idx_t [NUM_REQ-1:0]     req_rob_idx;

    logic [CDB_WIDTH-1:0]       cdb_bc;
    prf_idx_t [CDB_WIDTH-1:0]   cdb_prd_s;
    logic [CDB_WIDTH-1:0][31:0] cdb_prd_v;
    rob_idx_t [CDB_WIDTH-1:0]   cdb_rob_idx;

    // Execution units plus CDB consumers.
    modport master (
        output req_valid, req_prd_s, req_prd_v, req_rob_idx,
        input  req_ready, cdb_bc, cdb_prd_s, cdb_prd_v, cdb_rob_idx
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_prd_s, req_prd_v, req_rob_idx,
        output req_ready, cdb_bc, cdb_prd_s, cdb_prd_v, cdb_rob_idx
    );

endinterface

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin picker: grants the first CDB_WIDTH valid slots starting at rr_ptr.
module cdb_rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]                valid_i,
    input  logic [PtrW-1:0]                   rr_ptr_i,
    output logic [CDB_WIDTH-1:0][NUM_REQ-1:0] lane_sel_o,
    output logic [CDB_WIDTH-1:0]              lane_vld_o,
    output logic [PtrW-1:0]                   rr_ptr_next_o
);

    int unsigned idx;
    int unsigned cnt;

    // Scan slots in rotating order; the n-th valid slot found drives lane n.
    always_comb begin
        lane_sel_o    = '0;
        lane_vld_o    = '0;
        rr_ptr_next_o = rr_ptr_i;
        idx           = 0;
        cnt           = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_i) + k) % NUM_REQ;
            if (valid_i[idx] && (cnt < CDB_WIDTH)) begin
                lane_sel_o[cnt][idx] = 1'b1;
                lane_vld_o[cnt]      = 1'b1;
                rr_ptr_next_o        = PtrW'((idx + 1) % NUM_REQ);
                cnt                  = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per execution unit, round-robin grant onto registered lanes.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]             slot_vld_q, slot_vld_d;
    cdb_entry_t [NUM_REQ-1:0]       slot_q, slot_d;
    logic [CDB_WIDTH-1:0]           lane_bc_q, lane_bc_d;
    cdb_entry_t [CDB_WIDTH-1:0]     lane_q, lane_d;
    logic [PtrW-1:0]                rr_ptr_q, rr_ptr_d;

    logic [CDB_WIDTH-1:0][NUM_REQ-1:0] lane_sel;
    logic [CDB_WIDTH-1:0]              lane_vld;
    logic [PtrW-1:0]                   rr_ptr_next;
    logic [NUM_REQ-1:0]                grant;
    logic [NUM_REQ-1:0]                req_ready;

    cdb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PtrW    (PtrW)
    ) u_picker (
        .valid_i       (slot_vld_q),
        .rr_ptr_i      (rr_ptr_q),
        .lane_sel_o    (lane_sel),
        .lane_vld_o    (lane_vld),
        .rr_ptr_next_o (rr_ptr_next)
    );

    // A slot is free if empty or being granted now; ready never looks at req_valid.
    always_comb begin
        grant = '0;
        for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
            grant = grant | lane_sel[l];
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !flush && (!slot_vld_q[i] || grant[i]);
        end
    end

    assign bus.req_ready = req_ready;

    // Slot update: flush clears, accept loads (even over a granted entry), grant empties.
    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_d     = slot_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (flush) begin
                slot_vld_d[i] = 1'b0;
            end else if (bus.req_valid[i] && req_ready[i]) begin
                slot_vld_d[i]       = 1'b1;
                slot_d[i].prd_s     = bus.req_prd_s[i];
                slot_d[i].prd_v     = bus.req_prd_v[i];
                slot_d[i].rob_idx   = bus.req_rob_idx[i];
            end else if (grant[i]) begin
                slot_vld_d[i] = 1'b0;
            end
        end
    end

    // Lane mux from one-hot selects; idle lanes and flushed lanes carry all zeros.
    always_comb begin
        lane_bc_d = '0;
        lane_d    = '0;
        if (!flush) begin
            for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
                lane_bc_d[l] = lane_vld[l];
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (lane_sel[l][i]) begin
                        lane_d[l] = slot_q[i];
                    end
                end
            end
        end
    end

    // Round-robin pointer holds across a flush.
    always_comb begin
        rr_ptr_d = flush ? rr_ptr_q : rr_ptr_next;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q <= '0;
            slot_q     <= '0;
            lane_bc_q  <= '0;
            lane_q     <= '0;
            rr_ptr_q   <= '0;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_q     <= slot_d;
            lane_bc_q  <= lane_bc_d;
            lane_q     <= lane_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Unpack registered lanes onto the bus.
    always_comb begin
        bus.cdb_bc = lane_bc_q;
        for (int unsigned l = 0; l < CDB_WIDTH; l++) begin
            bus.cdb_prd_s[l]   = lane_q[l].prd_s;
            bus.cdb_prd_v[l]   = lane_q[l].prd_v;
            bus.cdb_rob_idx[l] = lane_q[l].rob_idx;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = CDB_WIDTH;

    typedef struct packed {
        logic [W-1:0]       bc;
        cdb_entry_t [W-1:0] e;
    } lanes_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    cdb_arbiter_if #(.NUM_REQ(N)) bus ();

    cdb_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: per-requester held result plus a scan pointer.
    bit          m_vld [N];
    cdb_entry_t  m_slot[N];
    int unsigned m_rr;
    lanes_t      exp_q[$];
    bit          mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    prf_idx_t    d_prd[N];
    logic [31:0] d_val[N];
    rob_idx_t    d_rob[N];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic lanes_t dut_lanes();
        lanes_t r;
        r.bc = bus.cdb_bc;
        for (int l = 0; l < W; l++) begin
            r.e[l].prd_s   = bus.cdb_prd_s[l];
            r.e[l].prd_v   = bus.cdb_prd_v[l];
            r.e[l].rob_idx = bus.cdb_rob_idx[l];
        end
        return r;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            d_prd[i] = prf_idx_t'($urandom);
            d_val[i] = $urandom;
            d_rob[i] = rob_idx_t'($urandom);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vld[i]  = 1'b0;
            m_slot[i] = '0;
        end
        m_rr = 0;
    endtask

    // Drive one cycle, check ready/pointer now, queue the lanes expected after the next edge.
    task automatic step(input logic [N-1:0] v, input logic fl);
        int unsigned gl[$];
        logic [N-1:0] granted;
        logic [N-1:0] exp_rdy;
        lanes_t nl;
        @(negedge clk);
        bus.req_valid = v;
        flush = fl;
        for (int i = 0; i < N; i++) begin
            bus.req_prd_s[i]   = d_prd[i];
            bus.req_prd_v[i]   = d_val[i];
            bus.req_rob_idx[i] = d_rob[i];
        end
        #1;
        granted = '0;
        for (int k = 0; k < N; k++) begin
            int unsigned idx;
            idx = (m_rr + k) % N;
            if (m_vld[idx] && gl.size() < W) begin
                gl.push_back(idx);
                granted[idx] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = !fl && (!m_vld[i] || granted[i]);
        end
        check("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
        check("rr_ptr", 128'(dut.rr_ptr_q), 128'(m_rr));
        nl = '0;
        if (fl) begin
            for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
        end else begin
            foreach (gl[n]) begin
                nl.bc[n] = 1'b1;
                nl.e[n]  = m_slot[gl[n]];
                m_vld[gl[n]] = 1'b0;
            end
            if (gl.size() > 0) m_rr = (gl[gl.size() - 1] + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_rdy[i]) begin
                    m_vld[i]  = 1'b1;
                    m_slot[i] = '{prd_s: d_prd[i], prd_v: d_val[i], rob_idx: d_rob[i]};
                end
            end
        end
        exp_q.push_back(nl);
        mon_en = 1'b1;
    endtask

    // Reset pulsed between edges: outputs must clear before the next clock edge.
    task automatic async_reset_pulse();
        @(negedge clk);
        bus.req_valid = '0;
        flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_lanes", 128'(dut_lanes()), 128'(0));
        check("rst_rr_ptr", 128'(dut.rr_ptr_q), 128'(0));
        check("rst_ready", 128'(bus.req_ready), 128'({N{1'b1}}));
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step('0, 1'b0);
    endtask

    // Monitor: compare every registered lane state against the oldest queued expectation.
    always @(posedge clk) begin : monitor
        lanes_t e;
        #2;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cdb_lanes: got %h with no expectation queued", dut_lanes());
            end else begin
                e = exp_q.pop_front();
                check("cdb_lanes", 128'(dut_lanes()), 128'(e));
            end
        end
    end

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < N; i++) begin
            d_prd[i] = '0;
            d_val[i] = '0;
            d_rob[i] = '0;
            bus.req_prd_s[i]   = '0;
            bus.req_prd_v[i]   = '0;
            bus.req_rob_idx[i] = '0;
        end
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset_lanes", 128'(dut_lanes()), 128'(0));
        check("reset_ready", 128'(bus.req_ready), 128'({N{1'b1}}));
        check("reset_rr_ptr", 128'(dut.rr_ptr_q), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single result on requester 0.
        d_prd[0] = 7'd5;
        d_val[0] = 32'hDEADBEEF;
        d_rob[0] = 6'd3;
        step(4'b0001, 1'b0);
        idle(3);

        // Burst from all four starting at rr_ptr 0.
        async_reset_pulse();
        rand_data();
        step(4'b1111, 1'b0);
        idle(3);

        // Fairness with three persistent requesters.
        for (int c = 0; c < 9; c++) begin
            rand_data();
            step(4'b0111, 1'b0);
        end
        idle(3);

        // Streaming on requester 1 with sequential ROB indices.
        for (int c = 0; c < 10; c++) begin
            rand_data();
            d_rob[1] = rob_idx_t'(c);
            step(4'b0010, 1'b0);
        end
        idle(3);

        // Flush with everything full and lanes busy.
        rand_data();
        step(4'b1111, 1'b0);
        rand_data();
        step(4'b1111, 1'b0);
        rand_data();
        step(4'b1111, 1'b1);
        idle(3);

        // Asynchronous reset mid-burst, then a fresh request.
        rand_data();
        step(4'b1111, 1'b0);
        rand_data();
        step(4'b1111, 1'b0);
        async_reset_pulse();
        rand_data();
        step(4'b0100, 1'b0);
        idle(3);

        // Random traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            rand_data();
            step(N'($urandom), ($urandom_range(0, 19) == 0));
        end
        idle(4);

        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
